// File: rtl/canvas_pixel_writer_pkg.sv
// Shared types and encoders for the canvas frame-buffer writer.
// Pixel word layout: [7:6] type tag; drawn pixels hold the pen color code
// in [1:0], camera pixels hold a 4-bit gray level in [5:2].
package canvas_pkg;

  localparam int H_PIXELS_DEF = 320;
  localparam int V_PIXELS_DEF = 180;

  localparam logic [1:0] PIX_DRAWN  = 2'b11;
  localparam logic [1:0] PIX_CAMERA = 2'b00;

  typedef enum logic [1:0] {
    YELLOW  = 2'd0,
    MAGENTA = 2'd1,
    GREEN   = 2'd2,
    RED     = 2'd3
  } pen_color_e;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_e;

  function automatic logic [7:0] encode_drawn(pen_color_e color);
    return {PIX_DRAWN, 4'b0000, color};
  endfunction

  // Luma approximation R + 2G + B (max 60), top four bits kept.
  function automatic logic [7:0] encode_gray(logic [11:0] rgb);
    logic [5:0] sum;
    sum = {2'b00, rgb[11:8]} + {1'b0, rgb[7:4], 1'b0} + {2'b00, rgb[3:0]};
    return {PIX_CAMERA, sum[5:2], 2'b00};
  endfunction

endpackage

// File: rtl/canvas_pixel_writer_if.sv
// Canvas BRAM port bundle: one read port (address out, data back) and one
// write port. master = pixel writer, slave = BRAM.
interface canvas_pixel_writer_if #(parameter int ADDR_W = 16);
  logic [ADDR_W-1:0] bram_raddr_out;
  logic [7:0]        bram_rdata_in;
  logic [ADDR_W-1:0] bram_waddr_out;
  logic [7:0]        bram_wdata_out;
  logic              bram_we_out;

  modport master (
    output bram_raddr_out, bram_waddr_out, bram_wdata_out, bram_we_out,
    input  bram_rdata_in
  );

  modport slave (
    input  bram_raddr_out, bram_waddr_out, bram_wdata_out, bram_we_out,
    output bram_rdata_in
  );
endinterface

// File: rtl/canvas_pixel_writer_cam_rmw_pipe.sv
// Camera read-before-write pipeline. Each accepted camera pixel reads its
// BRAM word, and the write is offered only if the word is not a drawn pixel
// and no pen write hit the same address while the read was in flight.
// Ports: clk/rst, flush (kill everything in flight), cam_vld/cam_addr/
// cam_word (accepted camera pixel), pen_wr/pen_addr (pen write issued next
// cycle), rtag (BRAM rdata type tag), raddr (BRAM read address),
// cam_wr/cam_waddr/cam_wdata (camera write candidate, combinational).
module cam_rmw_pipe import canvas_pkg::*; #(
  parameter int ADDR_W       = 16,
  parameter int BRAM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cam_vld,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [7:0]        cam_word,
  input  logic              pen_wr,
  input  logic [ADDR_W-1:0] pen_addr,
  input  logic [1:0]        rtag,
  output logic [ADDR_W-1:0] raddr,
  output logic              cam_wr,
  output logic [ADDR_W-1:0] cam_waddr,
  output logic [7:0]        cam_wdata
);
  // Stage 0 drives the read address; stage STAGES sees the read data.
  localparam int STAGES = BRAM_LATENCY;

  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0][ADDR_W-1:0] addr_pipe;
  logic [STAGES:0][7:0]        word_pipe;
  // Pen writes accepted over the last STAGES+1 cycles; together with the
  // live pen_wr this covers every pen write landing between the read
  // issue and the camera write slot.
  logic [STAGES:0]             hz_vld;
  logic [STAGES:0][ADDR_W-1:0] hz_addr;
  logic                        hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
      word_pipe <= '0;
      hz_vld    <= '0;
      hz_addr   <= '0;
    end else begin
      vld_pipe  <= flush ? '0 : {vld_pipe[STAGES-1:0], cam_vld};
      addr_pipe <= {addr_pipe[STAGES-1:0], cam_addr};
      word_pipe <= {word_pipe[STAGES-1:0], cam_word};
      hz_vld    <= {hz_vld[STAGES-1:0], pen_wr};
      hz_addr   <= {hz_addr[STAGES-1:0], pen_addr};
    end
  end

  always_comb begin
    hit = pen_wr && (pen_addr == addr_pipe[STAGES]);
    for (int k = 0; k <= STAGES; k++)
      if (hz_vld[k] && (hz_addr[k] == addr_pipe[STAGES])) hit = 1'b1;
  end

  assign raddr     = addr_pipe[0];
  assign cam_wr    = vld_pipe[STAGES] && !flush && !hit && (rtag != PIX_DRAWN);
  assign cam_waddr = addr_pipe[STAGES];
  assign cam_wdata = word_pipe[STAGES];

endmodule

// File: rtl/canvas_pixel_writer.sv
// Canvas frame-buffer write encoder. Merges camera background pixels, pen
// strokes and a full-canvas clear sweep into one BRAM write port.
// Write priority: clear sweep > pen > camera; camera never overwrites a
// drawn pixel.
// Ports: clk_in/rst_in (sync active-high), cam_* (camera stream, no
// backpressure), pen_* (valid/ready request), clear_in/clear_busy_out/
// clear_done_out (sweep control), bram (BRAM read + write ports).
module canvas_pixel_writer import canvas_pkg::*; #(
  parameter int H_PIXELS     = H_PIXELS_DEF,
  parameter int V_PIXELS     = V_PIXELS_DEF,
  parameter int ADDR_W       = 16,
  parameter int BRAM_LATENCY = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 cam_valid_in,
  input  logic [8:0]           cam_x_in,
  input  logic [7:0]           cam_y_in,
  input  logic [11:0]          cam_pixel_in,
  input  logic                 pen_valid_in,
  output logic                 pen_ready_out,
  input  logic [8:0]           pen_x_in,
  input  logic [7:0]           pen_y_in,
  input  logic [1:0]           pen_color_in,
  input  logic                 clear_in,
  output logic                 clear_busy_out,
  output logic                 clear_done_out,
  canvas_pixel_writer_if.master bram
);
  localparam logic [ADDR_W:0] CLR_END = (ADDR_W+1)'(H_PIXELS * V_PIXELS);

  state_e            state;
  logic [ADDR_W:0]   clr_cnt;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;

  logic              pen_wr, cam_vld, cam_wr;
  logic [ADDR_W-1:0] pen_addr, cam_addr, cam_waddr;
  logic [7:0]        cam_wdata;

  assign pen_addr = ADDR_W'(32'(pen_y_in) * H_PIXELS + 32'(pen_x_in));
  assign cam_addr = ADDR_W'(32'(cam_y_in) * H_PIXELS + 32'(cam_x_in));

  // Out-of-range pen requests still handshake but never write.
  assign pen_wr  = pen_valid_in && pen_ready_out &&
                   (32'(pen_x_in) < H_PIXELS) && (32'(pen_y_in) < V_PIXELS);
  assign cam_vld = cam_valid_in && (state == RUN) &&
                   (32'(cam_x_in) < H_PIXELS) && (32'(cam_y_in) < V_PIXELS);

  cam_rmw_pipe #(.ADDR_W(ADDR_W), .BRAM_LATENCY(BRAM_LATENCY)) u_cam (
    .clk       (clk_in),
    .rst       (rst_in),
    .flush     (state != RUN),
    .cam_vld   (cam_vld),
    .cam_addr  (cam_addr),
    .cam_word  (encode_gray(cam_pixel_in)),
    .pen_wr    (pen_wr),
    .pen_addr  (pen_addr),
    .rtag      (bram.bram_rdata_in[7:6]),
    .raddr     (bram.bram_raddr_out),
    .cam_wr    (cam_wr),
    .cam_waddr (cam_waddr),
    .cam_wdata (cam_wdata)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= RUN;
      clr_cnt        <= '0;
      pen_ready_out  <= 1'b0;
      clear_busy_out <= 1'b0;
      clear_done_out <= 1'b0;
      we             <= 1'b0;
      waddr          <= '0;
      wdata          <= '0;
    end else begin
      clear_done_out <= 1'b0;
      we             <= 1'b0;
      case (state)
        RUN: begin
          if (pen_wr) begin
            we    <= 1'b1;
            waddr <= pen_addr;
            wdata <= encode_drawn(pen_color_e'(pen_color_in));
          end else if (cam_wr) begin
            we    <= 1'b1;
            waddr <= cam_waddr;
            wdata <= cam_wdata;
          end
          // A pen accepted alongside clear_in writes first; sweep follows.
          if (clear_in) begin
            state          <= CLEAR;
            clr_cnt        <= '0;
            clear_busy_out <= 1'b1;
            pen_ready_out  <= 1'b0;
          end else begin
            pen_ready_out  <= 1'b1;
          end
        end
        CLEAR: begin
          // One extra cycle after the last address so done trails it.
          if (clr_cnt == CLR_END) begin
            state          <= RUN;
            clear_busy_out <= 1'b0;
            clear_done_out <= 1'b1;
            pen_ready_out  <= 1'b1;
          end else begin
            we      <= 1'b1;
            waddr   <= clr_cnt[ADDR_W-1:0];
            wdata   <= 8'h00;
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bram.bram_we_out    = we;
  assign bram.bram_waddr_out = waddr;
  assign bram.bram_wdata_out = wdata;

endmodule

// File: tb/tb_canvas_pixel_writer.sv
// Directed bench for canvas_pixel_writer with a 2-cycle-latency BRAM model.
module tb_canvas_pixel_writer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cam_valid = 1'b0;
  logic [8:0]  cam_x = '0;
  logic [7:0]  cam_y = '0;
  logic [11:0] cam_pixel = '0;
  logic        pen_valid = 1'b0;
  logic        pen_ready;
  logic [8:0]  pen_x = '0;
  logic [7:0]  pen_y = '0;
  logic [1:0]  pen_color = '0;
  logic        clear = 1'b0;
  logic        clear_busy, clear_done;

  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  canvas_pixel_writer_if #(.ADDR_W(16)) bram_if ();

  canvas_pixel_writer #(.H_PIXELS(320), .V_PIXELS(180), .ADDR_W(16), .BRAM_LATENCY(2)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .cam_valid_in   (cam_valid),
    .cam_x_in       (cam_x),
    .cam_y_in       (cam_y),
    .cam_pixel_in   (cam_pixel),
    .pen_valid_in   (pen_valid),
    .pen_ready_out  (pen_ready),
    .pen_x_in       (pen_x),
    .pen_y_in       (pen_y),
    .pen_color_in   (pen_color),
    .clear_in       (clear),
    .clear_busy_out (clear_busy),
    .clear_done_out (clear_done),
    .bram           (bram_if)
  );

  // BRAM model: raddr in cycle c -> rdata valid in cycle c+2.
  logic [7:0] mem [0:65535];
  logic [7:0] rd_p1;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bram_if.bram_we_out) mem[bram_if.bram_waddr_out] <= bram_if.bram_wdata_out;
    rd_p1 <= mem[bram_if.bram_raddr_out];
    bram_if.bram_rdata_in <= rd_p1;
  end

  // All tasks start and end on a negedge.
  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic cam_send(input logic [8:0] x, input logic [7:0] y, input logic [11:0] p);
    cam_valid = 1'b1; cam_x = x; cam_y = y; cam_pixel = p;
    @(negedge clk);
    cam_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (pen_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %0b want 0", pen_ready); end
    checks++;
    if ({bram_if.bram_we_out, clear_busy, clear_done} !== 3'b000) begin
      fails++; $display("FAIL reset_flags got %b want 000", {bram_if.bram_we_out, clear_busy, clear_done});
    end
    checks++;
    if ({bram_if.bram_waddr_out, bram_if.bram_wdata_out, bram_if.bram_raddr_out} !== 40'd0) begin
      fails++; $display("FAIL reset_buses got waddr=%0d wdata=%h raddr=%0d want 0",
                        bram_if.bram_waddr_out, bram_if.bram_wdata_out, bram_if.bram_raddr_out);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (pen_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset got %0b want 1", pen_ready); end
  endtask

  task automatic test_pen;
    pen_valid = 1'b1; pen_x = 9'd5; pen_y = 8'd1; pen_color = 2'd2;
    @(negedge clk);
    pen_valid = 1'b0;
    checks++;
    if ({bram_if.bram_we_out, bram_if.bram_waddr_out, bram_if.bram_wdata_out} !== {1'b1, 16'd325, 8'hC2}) begin
      fails++; $display("FAIL pen_write got we=%0b addr=%0d data=%h want 1/325/c2",
                        bram_if.bram_we_out, bram_if.bram_waddr_out, bram_if.bram_wdata_out);
    end
    @(negedge clk);
    checks++;
    if (bram_if.bram_we_out !== 1'b0) begin fails++; $display("FAIL pen_single got we=%0b want 0", bram_if.bram_we_out); end
  endtask

  task automatic test_camera;
    preload(16'd0, 8'h00);
    cam_send(9'd0, 8'd0, 12'hFFF);
    repeat (2) @(negedge clk);
    checks++;
    if (bram_if.bram_we_out !== 1'b0) begin fails++; $display("FAIL cam_early got we=%0b want 0 at t+3", bram_if.bram_we_out); end
    @(negedge clk);
    checks++;
    if ({bram_if.bram_we_out, bram_if.bram_waddr_out, bram_if.bram_wdata_out} !== {1'b1, 16'd0, 8'h3C}) begin
      fails++; $display("FAIL cam_write got we=%0b addr=%0d data=%h want 1/0/3c",
                        bram_if.bram_we_out, bram_if.bram_waddr_out, bram_if.bram_wdata_out);
    end
  endtask

  task automatic test_protect;
    preload(16'd325, 8'hC1);
    preload(16'd326, 8'h20);
    cam_send(9'd5, 8'd1, 12'h888);
    checks++;
    if (bram_if.bram_raddr_out !== 16'd325) begin fails++; $display("FAIL protect_raddr got %0d want 325", bram_if.bram_raddr_out); end
    repeat (3) @(negedge clk);
    checks++;
    if (bram_if.bram_we_out !== 1'b0) begin
      fails++; $display("FAIL protect_drawn got we=%0b addr=%0d want no write", bram_if.bram_we_out, bram_if.bram_waddr_out);
    end
    cam_send(9'd6, 8'd1, 12'h888);
    repeat (3) @(negedge clk);
    checks++;
    if ({bram_if.bram_we_out, bram_if.bram_waddr_out, bram_if.bram_wdata_out} !== {1'b1, 16'd326, 8'h20}) begin
      fails++; $display("FAIL protect_gray got we=%0b addr=%0d data=%h want 1/326/20",
                        bram_if.bram_we_out, bram_if.bram_waddr_out, bram_if.bram_wdata_out);
    end
  endtask

  task automatic test_hazard;
    preload(16'd10, 8'h00);
    cam_send(9'd10, 8'd0, 12'hFFF);
    @(negedge clk);
    pen_valid = 1'b1; pen_x = 9'd10; pen_y = 8'd0; pen_color = 2'd3;
    @(negedge clk);
    pen_valid = 1'b0;
    checks++;
    if ({bram_if.bram_we_out, bram_if.bram_waddr_out, bram_if.bram_wdata_out} !== {1'b1, 16'd10, 8'hC3}) begin
      fails++; $display("FAIL hazard_pen got we=%0b addr=%0d data=%h want 1/10/c3",
                        bram_if.bram_we_out, bram_if.bram_waddr_out, bram_if.bram_wdata_out);
    end
    @(negedge clk);
    checks++;
    if (bram_if.bram_we_out !== 1'b0) begin
      fails++; $display("FAIL hazard_cam got we=%0b data=%h want suppressed", bram_if.bram_we_out, bram_if.bram_wdata_out);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] ea [3];
    logic [7:0]  ed [3];
    ea = '{16'd20, 16'd21, 16'd22};
    ed = '{8'h00, 8'h1C, 8'h0C};
    preload(16'd20, 8'h00);
    preload(16'd21, 8'h00);
    preload(16'd22, 8'h00);
    cam_valid = 1'b1; cam_x = 9'd20; cam_y = 8'd0; cam_pixel = 12'h000;
    @(negedge clk);
    cam_x = 9'd21; cam_pixel = 12'h0F0;
    @(negedge clk);
    cam_x = 9'd22; cam_pixel = 12'hF00;
    @(negedge clk);
    cam_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bram_if.bram_we_out, bram_if.bram_waddr_out, bram_if.bram_wdata_out} !== {1'b1, ea[i], ed[i]}) begin
        fails++; $display("FAIL b2b_%0d got we=%0b addr=%0d data=%h want 1/%0d/%h", i,
                          bram_if.bram_we_out, bram_if.bram_waddr_out, bram_if.bram_wdata_out, ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_out_of_range;
    pen_valid = 1'b1; pen_x = 9'd320; pen_y = 8'd0; pen_color = 2'd1;
    cam_valid = 1'b1; cam_x = 9'd0; cam_y = 8'd180; cam_pixel = 12'hFFF;
    checks++;
    if (pen_ready !== 1'b1) begin fails++; $display("FAIL oor_accept got ready=%0b want 1", pen_ready); end
    @(negedge clk);
    pen_valid = 1'b0; cam_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bram_if.bram_we_out !== 1'b0) begin fails++; $display("FAIL oor_nowrite_%0d got we=1 addr=%0d want 0", i, bram_if.bram_waddr_out); end
      @(negedge clk);
    end
  endtask

  task automatic test_clear;
    int bad = 0;
    clear = 1'b1;
    pen_valid = 1'b1; pen_x = 9'd7; pen_y = 8'd0; pen_color = 2'd0;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if ({bram_if.bram_we_out, bram_if.bram_waddr_out, bram_if.bram_wdata_out} !== {1'b1, 16'd7, 8'hC0}) begin
      fails++; $display("FAIL clear_pen_first got we=%0b addr=%0d data=%h want 1/7/c0",
                        bram_if.bram_we_out, bram_if.bram_waddr_out, bram_if.bram_wdata_out);
    end
    checks++;
    if ({clear_busy, pen_ready} !== 2'b10) begin fails++; $display("FAIL clear_enter got busy,ready=%b want 10", {clear_busy, pen_ready}); end
    // Pen and camera kept asserted during the sweep: both must be ignored.
    cam_valid = 1'b1; cam_x = 9'd3; cam_y = 8'd3; cam_pixel = 12'hFFF;
    for (int i = 0; i < 57600; i++) begin
      @(negedge clk);
      if ({bram_if.bram_we_out, bram_if.bram_waddr_out, bram_if.bram_wdata_out, pen_ready, clear_busy, clear_done}
          !== {1'b1, 16'(i), 8'h00, 1'b0, 1'b1, 1'b0}) begin
        if (bad == 0)
          $display("FAIL clear_sweep at %0d got we=%0b addr=%0d data=%h ready=%0b busy=%0b done=%0b", i,
                   bram_if.bram_we_out, bram_if.bram_waddr_out, bram_if.bram_wdata_out, pen_ready, clear_busy, clear_done);
        bad++;
      end
      clear = (i == 100);
      if (i == 57599) begin pen_valid = 1'b0; cam_valid = 1'b0; end
    end
    checks++;
    if (bad != 0) begin fails++; $display("FAIL clear_sweep_total got %0d bad cycles want 0", bad); end
    @(negedge clk);
    checks++;
    if ({clear_done, clear_busy, pen_ready, bram_if.bram_we_out} !== 4'b1010) begin
      fails++; $display("FAIL clear_done got done,busy,ready,we=%b want 1010",
                        {clear_done, clear_busy, pen_ready, bram_if.bram_we_out});
    end
    @(negedge clk);
    checks++;
    if ({clear_done, bram_if.bram_we_out} !== 2'b00) begin
      fails++; $display("FAIL clear_done_once got done,we=%b want 00", {clear_done, bram_if.bram_we_out});
    end
  endtask

  task automatic test_reset_mid_clear;
    logic found = 1'b0;
    int   dones = 0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (bram_if.bram_we_out === 1'b1 && bram_if.bram_waddr_out === 16'd1000) found = 1'b1;
    end
    checks++;
    if (!found) begin fails++; $display("FAIL midclear_reach got no write to 1000 want one within 3000 cycles"); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bram_if.bram_we_out, clear_busy, clear_done, pen_ready, bram_if.bram_waddr_out} !== 20'd0) begin
      fails++; $display("FAIL midclear_reset got we=%0b busy=%0b done=%0b ready=%0b waddr=%0d want all 0",
                        bram_if.bram_we_out, clear_busy, clear_done, pen_ready, bram_if.bram_waddr_out);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (clear_done === 1'b1 || bram_if.bram_we_out === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin fails++; $display("FAIL midclear_nodone got %0d done/write cycles want 0", dones); end
    checks++;
    if ({clear_busy, pen_ready} !== 2'b01) begin fails++; $display("FAIL midclear_run got busy,ready=%b want 01", {clear_busy, pen_ready}); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_pen();
    test_camera();
    test_protect();
    test_hazard();
    test_back_to_back();
    test_out_of_range();
    test_clear();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want test completion");
    $fatal(1, "watchdog");
  end

endmodule
